// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_skid
// Description : Two-entry valid/ready pipeline stage (main + skid) with flush
//               and saturating stall/flush statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_skid #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [CNT_W-1:0]  c_cnt_max   = '1;
    localparam logic [CTRL_W-1:0] c_ctrl_zero = '0;
    localparam logic [DATA_W-1:0] c_data_zero = '0;

    logic              r_main_valid;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;
    logic              r_skid_valid;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic              w_in_xfer;
    logic              w_out_xfer;
    logic              w_load_main;
    logic              w_stall_inc;
    logic              w_flush_hit;

    logic              w_main_valid;
    logic [CTRL_W-1:0] w_main_ctrl;
    logic [DATA_W-1:0] w_main_data;
    logic              w_skid_valid;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [DATA_W-1:0] w_skid_data;

    // in_ready comes straight from the skid flop, so out_ready never reaches it
    assign in_ready   = ~r_skid_valid;
    assign out_valid  = r_main_valid;
    assign out_ctrl   = r_main_ctrl;
    assign out_data   = r_main_data;
    assign stall_cnt  = r_stall_cnt;
    assign flush_cnt  = r_flush_cnt;

    assign w_in_xfer   = in_valid & ~r_skid_valid;
    assign w_out_xfer  = r_main_valid & out_ready;
    assign w_load_main = w_in_xfer & (~r_main_valid | w_out_xfer);
    assign w_stall_inc = r_main_valid & ~out_ready & ~flush;
    assign w_flush_hit = flush & (r_main_valid | r_skid_valid);

    always_comb begin
        w_main_valid = r_main_valid;
        w_main_ctrl  = r_main_ctrl;
        w_main_data  = r_main_data;
        w_skid_valid = r_skid_valid;
        w_skid_ctrl  = r_skid_ctrl;
        w_skid_data  = r_skid_data;

        if (flush) begin
            w_main_valid = 1'b0;
            w_main_ctrl  = c_ctrl_zero;
            w_main_data  = c_data_zero;
            w_skid_valid = 1'b0;
            w_skid_ctrl  = c_ctrl_zero;
            w_skid_data  = c_data_zero;
        end else begin
            if (w_out_xfer && r_skid_valid) begin
                // skid is full so no input transfer can coincide with this move
                w_main_valid = 1'b1;
                w_main_ctrl  = r_skid_ctrl;
                w_main_data  = r_skid_data;
                w_skid_valid = 1'b0;
                w_skid_ctrl  = c_ctrl_zero;
                w_skid_data  = c_data_zero;
            end else if (w_load_main) begin
                w_main_valid = 1'b1;
                w_main_ctrl  = in_ctrl;
                w_main_data  = in_data;
            end else if (w_out_xfer) begin
                w_main_valid = 1'b0;
                w_main_ctrl  = c_ctrl_zero;
                w_main_data  = c_data_zero;
            end

            if (w_in_xfer && !w_load_main) begin
                w_skid_valid = 1'b1;
                w_skid_ctrl  = in_ctrl;
                w_skid_data  = in_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_main_ctrl  <= c_ctrl_zero;
            r_main_data  <= c_data_zero;
            r_skid_valid <= 1'b0;
            r_skid_ctrl  <= c_ctrl_zero;
            r_skid_data  <= c_data_zero;
        end else begin
            r_main_valid <= w_main_valid;
            r_main_ctrl  <= w_main_ctrl;
            r_main_data  <= w_main_data;
            r_skid_valid <= w_skid_valid;
            r_skid_ctrl  <= w_skid_ctrl;
            r_skid_data  <= w_skid_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (cnt_clr) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_inc && (r_stall_cnt != c_cnt_max)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush_hit && (r_flush_cnt != c_cnt_max)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_skid
// Description : Self-checking bench for pipe_stage_skid (vector table,
//               directed corner sequences, random scoreboard run).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 16;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic              flush;
    logic              cnt_clr;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    int total  = 0;
    int passed = 0;

    pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .flush(flush), .cnt_clr(cnt_clr), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        fl;
        logic        clr;
        logic        eov;
        logic [31:0] eod;
        logic        eir;
        logic [3:0]  est;
        logic [3:0]  efc;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] sbq[$];

    function automatic logic [15:0] ctrl_of(input logic [31:0] d);
        return d[15:0] ^ 16'h5A3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic addv(input logic iv, input logic [31:0] d, input logic ordy,
                        input logic fl, input logic clr, input logic eov,
                        input logic [31:0] eod, input logic eir,
                        input logic [3:0] est, input logic [3:0] efc);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl; v.clr = clr;
        v.eov = eov; v.eod = eod; v.eir = eir; v.est = est; v.efc = efc;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic iv, input logic [31:0] d, input logic ordy,
                         input logic fl, input logic clr);
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = iv ? ctrl_of(d) : 16'h0;
        out_ready = ordy;
        flush     = fl;
        cnt_clr   = clr;
    endtask

    task automatic chk_out(input string tag, input logic eov, input logic [31:0] eod);
        chk({tag, " out_valid"}, 32'(out_valid), 32'(eov));
        chk({tag, " out_data"}, out_data, eod);
        chk({tag, " out_ctrl"}, 32'(out_ctrl), eov ? 32'(ctrl_of(eod)) : 32'h0);
    endtask

    initial begin
        logic        ir_before;
        logic        iv_r, ordy_r, fl_r;
        logic [31:0] exp_d;
        int          drain;

        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk_out("reset", 1'b0, 32'h0);
        chk("reset in_ready", 32'(in_ready), 32'h1);
        chk("reset stall_cnt", 32'(stall_cnt), 32'h0);
        chk("reset flush_cnt", 32'(flush_cnt), 32'h0);
        rst = 1'b0;

        // Each row: expected outputs in this cycle, then inputs for the coming edge
        for (int k = 0; k < 8; k++)
            addv(1, 32'(k + 1), 1, 0, 0, k != 0, (k == 0) ? 32'h0 : 32'(k), 1, 0, 0);
        addv(0, 32'h00, 1, 0, 0, 1, 32'h08, 1, 0, 0);
        addv(0, 32'h00, 1, 0, 0, 0, 32'h00, 1, 0, 0);
        addv(1, 32'h0A, 0, 0, 0, 0, 32'h00, 1, 0, 0);
        addv(1, 32'h0B, 0, 0, 0, 1, 32'h0A, 1, 0, 0);
        addv(0, 32'h00, 0, 0, 0, 1, 32'h0A, 0, 1, 0);
        addv(0, 32'h00, 0, 0, 0, 1, 32'h0A, 0, 2, 0);
        addv(0, 32'h00, 0, 0, 0, 1, 32'h0A, 0, 3, 0);
        addv(0, 32'h00, 0, 0, 0, 1, 32'h0A, 0, 4, 0);
        addv(0, 32'h00, 1, 0, 0, 1, 32'h0A, 0, 5, 0);
        addv(0, 32'h00, 1, 0, 0, 1, 32'h0B, 1, 5, 0);
        addv(1, 32'h10, 0, 0, 0, 0, 32'h00, 1, 5, 0);
        addv(1, 32'h11, 0, 0, 0, 1, 32'h10, 1, 5, 0);
        addv(1, 32'h0C, 0, 1, 0, 1, 32'h10, 0, 6, 0);
        addv(0, 32'h00, 1, 0, 0, 0, 32'h00, 1, 6, 1);
        addv(1, 32'h0D, 1, 1, 0, 0, 32'h00, 1, 6, 1);
        addv(0, 32'h00, 1, 0, 1, 0, 32'h00, 1, 6, 1);
        addv(0, 32'h00, 1, 0, 0, 0, 32'h00, 1, 0, 0);

        foreach (tbl[i]) begin
            chk_out($sformatf("vec%0d", i), tbl[i].eov, tbl[i].eod);
            chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(tbl[i].eir));
            chk($sformatf("vec%0d stall_cnt", i), 32'(stall_cnt), 32'(tbl[i].est));
            chk($sformatf("vec%0d flush_cnt", i), 32'(flush_cnt), 32'(tbl[i].efc));
            drive(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl, tbl[i].clr);
            @(negedge clk);
        end

        // Stall counter saturation and clear during a stall cycle
        drive(1, 32'h20, 0, 0, 0);
        @(negedge clk);
        drive(0, 32'h0, 0, 0, 0);
        repeat (19) @(negedge clk);
        chk("sat stall_cnt", 32'(stall_cnt), 32'hF);
        chk_out("sat", 1'b1, 32'h20);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        chk("clr stall_cnt", 32'(stall_cnt), 32'h0);
        @(negedge clk);
        chk("post-clr stall_cnt", 32'(stall_cnt), 32'h1);
        out_ready = 1'b1;
        @(negedge clk);
        chk_out("sat drain", 1'b0, 32'h0);

        // Asynchronous reset between edges with both entries held
        drive(1, 32'h30, 0, 0, 0);
        @(negedge clk);
        drive(1, 32'h31, 0, 0, 0);
        @(negedge clk);
        drive(0, 32'h0, 0, 0, 0);
        chk("pre-rst in_ready", 32'(in_ready), 32'h0);
        #2 rst = 1'b1;
        #1;
        chk_out("async rst", 1'b0, 32'h0);
        chk("async rst in_ready", 32'(in_ready), 32'h1);
        chk("async rst stall_cnt", 32'(stall_cnt), 32'h0);
        chk("async rst flush_cnt", 32'(flush_cnt), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 32'h05, 1, 0, 0);
        @(posedge clk);
        #1;
        chk_out("post-rst", 1'b1, 32'h05);
        @(negedge clk);
        drive(0, 32'h0, 1, 0, 0);
        @(negedge clk);

        // Random traffic against a queue scoreboard
        for (int c = 0; c < 10000; c++) begin
            if (!out_valid) chk("rand idle out_ctrl", 32'(out_ctrl), 32'h0);
            iv_r   = ($urandom_range(0, 99) < 60);
            ordy_r = ($urandom_range(0, 99) < 55);
            fl_r   = ($urandom_range(0, 99) < 2);
            drive(iv_r, $urandom, ordy_r, fl_r, 1'b0);
            ir_before = in_ready;
            out_ready = ~ordy_r;
            #1;
            chk("rand in_ready vs out_ready", 32'(in_ready), 32'(ir_before));
            out_ready = ordy_r;
            #1;
            if (out_valid && ordy_r) begin
                if (sbq.size() == 0) begin
                    chk("rand unexpected output", out_data, 32'hDEAD_BEEF);
                end else begin
                    exp_d = sbq.pop_front();
                    chk("rand out_data", out_data, exp_d);
                    chk("rand out_ctrl", 32'(out_ctrl), 32'(ctrl_of(exp_d)));
                end
            end
            if (fl_r) sbq.delete();
            else if (iv_r && in_ready) sbq.push_back(in_data);
            @(negedge clk);
        end

        drive(0, 32'h0, 1, 0, 0);
        drain = 0;
        while (sbq.size() != 0 && drain < 8) begin
            if (out_valid) begin
                exp_d = sbq.pop_front();
                chk("drain out_data", out_data, exp_d);
            end
            drain++;
            @(negedge clk);
        end
        chk("drain queue empty", 32'(sbq.size()), 32'h0);
        chk("drain out_valid", 32'(out_valid), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
